ro_block_slot_n: RTL

- Parametrised readout slot controller for one cochlea core; the next generation of the per-core gray-slot readout blocks.
- Accumulates event and polarity-event pulses from NCH channels between readout slots.
- Detects each toggle of its assigned gray-counter bit and drives the captured bits onto the shared tristate readout bus for WIN cycles.
- Adds what the per-core blocks lack: selectable slot bit, multi-channel width, sticky accumulation, overflow and missed-slot flags, and a fully synchronous window.

---
 rtl/ro_block_slot_n.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ro_block_slot_n.sv
// ro_block_slot_n: per-core readout slot controller. Collects event and
//   polarity-event pulses from NCH channels and puts them on the shared
//   tristate bus once per toggle of its gray-counter slot bit.
// Latency: slot toggle sampled at edge k -> bus driven from edge k+1 through k+WIN.
// Backpressure: none; a toggle that arrives while the bus is driven is dropped
//   and flagged on slot_miss, and its pending data stays in the accumulator.
//
// Ports:
//   clk_master               single clock, all state on posedge
//   reset                    synchronous active-high reset
//   enable                   arms slot detection (a running window always completes)
//   gray[GRAY_W]             shared gray counter; only bit SLOT_IDX-1 is used
//   in_eve/in_pol_eve[NCH]   per-channel event / polarity-event pulses
//   out_eve/out_pol_eve[NCH] captured bits while out_oe=1, Z otherwise
//   out_oe                   high while this block owns the bus
//   ovf[2*NCH]               sticky overflow: [NCH-1:0] eve, [2NCH-1:NCH] pol
//   slot_miss                sticky: a slot toggle arrived during a window
module ro_block_slot_n #(
  parameter int NCH      = 2,
  parameter int GRAY_W   = 19,
  parameter int SLOT_IDX = 3,
  parameter int WIN      = 1,
  parameter int STICKY   = 1
) (
  input  logic              clk_master,
  input  logic              reset,
  input  logic              enable,
  input  logic [GRAY_W-1:0] gray,
  input  logic [NCH-1:0]    in_eve,
  input  logic [NCH-1:0]    in_pol_eve,
  output logic [NCH-1:0]    out_eve,
  output logic [NCH-1:0]    out_pol_eve,
  output logic              out_oe,
  output logic [2*NCH-1:0]  ovf,
  output logic              slot_miss
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_gray_q;
  logic [NCH-1:0]   r_acc_eve;
  logic [NCH-1:0]   r_acc_pol;
  logic [NCH-1:0]   r_sh_eve;
  logic [NCH-1:0]   r_sh_pol;
  logic [CW-1:0]    r_cnt;
  logic [2*NCH-1:0] r_ovf;
  logic             r_miss;

  logic             w_slot;
  logic             w_tog;
  logic             w_cap;
  logic [NCH-1:0]   w_cap_eve;
  logic [NCH-1:0]   w_cap_pol;
  logic             w_unused_gray;

  // Only one bit of the shared counter belongs to this slot.
  assign w_unused_gray = ^gray;
  assign w_slot        = gray[SLOT_IDX-1];
  assign w_tog         = w_slot ^ r_gray_q;
  assign w_cap         = (r_state == IDLE) && w_tog && enable;

  // In non-sticky mode only what is present in the capture cycle is read out.
  assign w_cap_eve = (STICKY != 0) ? (r_acc_eve | in_eve)     : in_eve;
  assign w_cap_pol = (STICKY != 0) ? (r_acc_pol | in_pol_eve) : in_pol_eve;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tog && enable) w_state_nxt = DRIVE;
      DRIVE:   if (r_cnt == '0)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gray_q  <= w_slot;
      r_acc_eve <= '0;
      r_acc_pol <= '0;
      r_sh_eve  <= '0;
      r_sh_pol  <= '0;
      r_cnt     <= '0;
      r_ovf     <= '0;
      r_miss    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gray_q <= w_slot;

      if (w_cap) begin
        // A pulse in the capture cycle lands in the shadow only.
        r_sh_eve  <= w_cap_eve;
        r_sh_pol  <= w_cap_pol;
        r_acc_eve <= '0;
        r_acc_pol <= '0;
        r_cnt     <= CW'(WIN - 1);
      end else begin
        if (STICKY != 0) begin
          r_acc_eve <= r_acc_eve | in_eve;
          r_acc_pol <= r_acc_pol | in_pol_eve;
        end
        // Second pulse on a channel before it was read out; acc stays 0
        // in non-sticky mode so this never fires there.
        r_ovf <= r_ovf | {in_pol_eve & r_acc_pol, in_eve & r_acc_eve};
        if (r_state == DRIVE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end

      if (r_state == DRIVE && w_tog) r_miss <= 1'b1;
    end
  end

  // out_oe decodes straight from the state register: no input-to-output path.
  assign out_oe      = (r_state == DRIVE);
  assign out_eve     = out_oe ? r_sh_eve : {NCH{1'bz}};
  assign out_pol_eve = out_oe ? r_sh_pol : {NCH{1'bz}};
  assign ovf         = r_ovf;
  assign slot_miss   = r_miss;

endmodule
